// File: rtl/rcu_nw_freelist.sv
// N-allocate / M-free physical-register freelist with a committed read pointer for one-cycle flush.
// Optional sticky error flag err_o is present when RCU_FREELIST_ERR_EN is defined.
module rcu_nw_freelist #(
    parameter int unsigned PREG_WIDTH  = 6,
    parameter int unsigned NUM_PREGS   = 64,
    parameter int unsigned NUM_ARCH    = 32,
    parameter int unsigned ALLOC_PORTS = 2,
    parameter int unsigned FREE_PORTS  = 2,
    parameter int unsigned CNT_WIDTH   = $clog2(NUM_PREGS - NUM_ARCH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [ALLOC_PORTS-1:0]            alloc_req_i,
    output logic                              alloc_ready_o,
    output logic [ALLOC_PORTS*PREG_WIDTH-1:0] alloc_preg_o,
    input  logic [ALLOC_PORTS-1:0]            commit_i,
    input  logic [FREE_PORTS-1:0]             free_en_i,
    input  logic [FREE_PORTS*PREG_WIDTH-1:0]  free_preg_i,
    output logic [CNT_WIDTH-1:0]              free_cnt_o,
    output logic                              empty_o,
    output logic                              full_o
`ifdef RCU_FREELIST_ERR_EN
    ,
    output logic                              err_o
`endif
);

    localparam int unsigned DEPTH = NUM_PREGS - NUM_ARCH;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_WIDTH + 3;

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [SUM_W-1:0]      sum_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic ptr_t ptr_add(input ptr_t p, input sum_t inc);
        sum_t s;
        s = sum_t'(p) + inc;
        return ptr_t'(s % sum_t'(DEPTH));
    endfunction

    preg_t          mem_q [DEPTH];
    ptr_t           wr_ptr_q, wr_ptr_d;
    ptr_t           spec_rd_ptr_q, spec_rd_ptr_d;
    ptr_t           cmt_rd_ptr_q, cmt_rd_ptr_d;
    logic [CNT_WIDTH-1:0] spec_cnt_q, spec_cnt_d;
    logic [CNT_WIDTH-1:0] cmt_cnt_q, cmt_cnt_d;

    sum_t           n_req;
    sum_t           n_cmt;
    sum_t           n_free;
    sum_t           n_acc;
    sum_t           cmt_left;
    sum_t           room;
    sum_t           spec_sum;
    sum_t           alloc_rank [ALLOC_PORTS];
    sum_t           free_rank  [FREE_PORTS];
    ptr_t           free_idx   [FREE_PORTS];
    logic [FREE_PORTS-1:0] free_we;
    logic           alloc_fire;
    logic           cmt_illegal;
    logic           free_drop;

    // Allocation: requested lanes are packed onto consecutive entries from spec_rd_ptr.
    always_comb begin
        n_req        = '0;
        alloc_preg_o = '0;
        for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
            alloc_rank[k] = n_req;
            n_req         = n_req + sum_t'(alloc_req_i[k]);
        end
        alloc_ready_o = (sum_t'(spec_cnt_q) >= n_req);
        alloc_fire    = (n_req != '0) && alloc_ready_o && !flush_i;
        for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
            if (alloc_req_i[k]) begin
                alloc_preg_o[k*PREG_WIDTH +: PREG_WIDTH] =
                    mem_q[ptr_add(spec_rd_ptr_q, alloc_rank[k])];
            end
        end
    end

    // Commit and free accounting; frees beyond the committed room are dropped from the top lanes.
    always_comb begin
        n_cmt = '0;
        for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
            n_cmt = n_cmt + sum_t'(commit_i[k]);
        end
        cmt_illegal = (n_cmt > sum_t'(cmt_cnt_q));
        cmt_left    = cmt_illegal ? '0 : sum_t'(cmt_cnt_q) - n_cmt;
        room        = sum_t'(DEPTH) - cmt_left;

        n_free = '0;
        for (int j = 0; j < int'(FREE_PORTS); j++) begin
            free_rank[j] = n_free;
            n_free       = n_free + sum_t'(free_en_i[j]);
        end
        free_drop = (n_free > room);
        n_acc     = free_drop ? room : n_free;

        free_we = '0;
        for (int j = 0; j < int'(FREE_PORTS); j++) begin
            free_idx[j] = ptr_add(wr_ptr_q, free_rank[j]);
            free_we[j]  = free_en_i[j] && (free_rank[j] < n_acc);
        end
    end

    // Next-state for pointers and counters; flush reloads speculative state from committed state.
    always_comb begin
        wr_ptr_d     = ptr_add(wr_ptr_q, n_acc);
        cmt_rd_ptr_d = ptr_add(cmt_rd_ptr_q, n_cmt);
        cmt_cnt_d    = CNT_WIDTH'(cmt_left + n_acc);
        spec_sum     = '0;
        if (flush_i) begin
            spec_rd_ptr_d = cmt_rd_ptr_d;
            spec_cnt_d    = cmt_cnt_d;
        end else begin
            spec_rd_ptr_d = alloc_fire ? ptr_add(spec_rd_ptr_q, n_req) : spec_rd_ptr_q;
            spec_sum      = sum_t'(spec_cnt_q) - (alloc_fire ? n_req : '0) + n_acc;
            // Only reachable after illegal commits; keep the count within the array.
            if (spec_sum > sum_t'(DEPTH)) begin
                spec_sum = sum_t'(DEPTH);
            end
            spec_cnt_d = CNT_WIDTH'(spec_sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= PREG_WIDTH'(NUM_ARCH + i);
            end
            wr_ptr_q      <= '0;
            spec_rd_ptr_q <= '0;
            cmt_rd_ptr_q  <= '0;
            spec_cnt_q    <= CNT_WIDTH'(DEPTH);
            cmt_cnt_q     <= CNT_WIDTH'(DEPTH);
        end else begin
            for (int j = 0; j < int'(FREE_PORTS); j++) begin
                if (free_we[j]) begin
                    mem_q[free_idx[j]] <= free_preg_i[j*PREG_WIDTH +: PREG_WIDTH];
                end
            end
            wr_ptr_q      <= wr_ptr_d;
            spec_rd_ptr_q <= spec_rd_ptr_d;
            cmt_rd_ptr_q  <= cmt_rd_ptr_d;
            spec_cnt_q    <= spec_cnt_d;
            cmt_cnt_q     <= cmt_cnt_d;
        end
    end

`ifdef RCU_FREELIST_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q | cmt_illegal | free_drop | ((n_req != '0) && !alloc_ready_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign free_cnt_o = spec_cnt_q;
    assign empty_o    = (spec_cnt_q == '0);
    assign full_o     = (spec_cnt_q == CNT_WIDTH'(DEPTH));

endmodule

// File: tb/tb_rcu_nw_freelist.sv
// Bench for rcu_nw_freelist: directed scenarios plus randomized traffic against a queue model.
module tb_rcu_nw_freelist;

    localparam int PW    = 6;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    alloc_req;
    logic          alloc_ready;
    logic [2*PW-1:0] alloc_preg;
    logic [1:0]    commit;
    logic [1:0]    free_en;
    logic [2*PW-1:0] free_preg;
    logic [CW-1:0] free_cnt;
    logic          empty;
    logic          full;
`ifdef RCU_FREELIST_ERR_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    // Model: q holds every tag from the committed read point to the write point, oldest first;
    // the first 'inflight' of them are allocated but not yet committed.
    int q[$];
    int inflight;

    rcu_nw_freelist #(
        .PREG_WIDTH (6),
        .NUM_PREGS  (64),
        .NUM_ARCH   (32),
        .ALLOC_PORTS(2),
        .FREE_PORTS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .alloc_req_i  (alloc_req),
        .alloc_ready_o(alloc_ready),
        .alloc_preg_o (alloc_preg),
        .commit_i     (commit),
        .free_en_i    (free_en),
        .free_preg_i  (free_preg),
        .free_cnt_o   (free_cnt),
        .empty_o      (empty),
        .full_o       (full)
`ifdef RCU_FREELIST_ERR_EN
        ,
        .err_o        (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int lane(input int k);
        return int'(alloc_preg[k*PW +: PW]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        alloc_req = 2'b00;
        commit    = 2'b00;
        free_en   = 2'b00;
        free_preg = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (int'(free_cnt) !== 32 || full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL reset_counts: cnt=%0d full=%b empty=%b, want 32/1/0", free_cnt, full, empty);
        end
        alloc_req = 2'b11;
        #1;
        checks++;
        if (alloc_ready !== 1'b1 || lane(0) !== 32 || lane(1) !== 33) begin
            errors++;
            $display("FAIL reset_first_grant: rdy=%b l0=%0d l1=%0d, want 1/32/33",
                     alloc_ready, lane(0), lane(1));
        end
        cycle();
        cycle();
        // Asynchronous reset mid-operation, no clock edge in between.
        rst = 1'b1;
        #1;
        checks++;
        if (int'(free_cnt) !== 32 || lane(0) !== 32) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d l0=%0d, want 32/32", free_cnt, lane(0));
        end
        rst = 1'b0;
        idle_inputs();
        #1;
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_req = 2'b11;
            #1;
            checks++;
            if (alloc_ready !== 1'b1 || lane(0) !== 32 + 2*i || lane(1) !== 33 + 2*i) begin
                errors++;
                $display("FAIL drain_grant[%0d]: rdy=%b l0=%0d l1=%0d, want 1/%0d/%0d",
                         i, alloc_ready, lane(0), lane(1), 32 + 2*i, 33 + 2*i);
            end
            cycle();
        end
        checks++;
        if (alloc_ready !== 1'b0 || empty !== 1'b1 || int'(free_cnt) !== 0) begin
            errors++;
            $display("FAIL drain_empty: rdy=%b empty=%b cnt=%0d, want 0/1/0",
                     alloc_ready, empty, free_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_compact();
        do_reset();
        alloc_req = 2'b10;
        #1;
        checks++;
        if (lane(1) !== 32 || lane(0) !== 0) begin
            errors++;
            $display("FAIL compact_single: l1=%0d l0=%0d, want 32/0", lane(1), lane(0));
        end
        cycle();
        alloc_req = 2'b11;
        #1;
        checks++;
        if (lane(0) !== 33 || lane(1) !== 34) begin
            errors++;
            $display("FAIL compact_pair: l0=%0d l1=%0d, want 33/34", lane(0), lane(1));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_blocked();
        do_reset();
        alloc_req = 2'b11;
        repeat (15) cycle();
        alloc_req = 2'b01;
        cycle();
        alloc_req = 2'b11;
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || int'(free_cnt) !== 1) begin
            errors++;
            $display("FAIL blocked_ready: rdy=%b cnt=%0d, want 0/1", alloc_ready, free_cnt);
        end
        cycle();
        checks++;
        if (int'(free_cnt) !== 1) begin
            errors++;
            $display("FAIL blocked_hold: cnt=%0d, want 1", free_cnt);
        end
        alloc_req = 2'b01;
        #1;
        checks++;
        if (alloc_ready !== 1'b1 || lane(0) !== 63) begin
            errors++;
            $display("FAIL blocked_last: rdy=%b l0=%0d, want 1/63", alloc_ready, lane(0));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 2'b11;
        repeat (3) cycle();
        alloc_req = 2'b00;
        commit    = 2'b11;
        cycle();
        commit = 2'b00;
        flush  = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (int'(free_cnt) !== 30) begin
            errors++;
            $display("FAIL flush_count: cnt=%0d, want 30", free_cnt);
        end
        alloc_req = 2'b11;
        #1;
        checks++;
        if (lane(0) !== 34 || lane(1) !== 35) begin
            errors++;
            $display("FAIL flush_oldest: l0=%0d l1=%0d, want 34/35", lane(0), lane(1));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        alloc_req = 2'b11;
        repeat (16) cycle();
        alloc_req = 2'b00;
        commit    = 2'b11;
        repeat (16) cycle();
        commit  = 2'b00;
        free_en = 2'b01;
        for (int i = 0; i < 31; i++) begin
            free_preg = {6'd0, 6'(i)};
            cycle();
        end
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            alloc_req = (i == 15) ? 2'b01 : 2'b11;
            #1;
            if (lane(0) !== 2*i || (i != 15 && lane(1) !== 2*i + 1)) bad++;
            cycle();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wrap_refill: %0d bad grant cycles, want 0", bad);
        end
        alloc_req = 2'b00;
        for (int i = 0; i < 16; i++) begin
            commit = (i == 15) ? 2'b01 : 2'b11;
            cycle();
        end
        commit = 2'b00;
        #1;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty: empty=%b, want 1", empty);
        end
        free_en   = 2'b11;
        free_preg = {6'd41, 6'd40};
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (int'(free_cnt) !== 2) begin
            errors++;
            $display("FAIL wrap_count: cnt=%0d, want 2", free_cnt);
        end
        alloc_req = 2'b11;
        #1;
        checks++;
        if (lane(0) !== 40 || lane(1) !== 41) begin
            errors++;
            $display("FAIL wrap_grant: l0=%0d l1=%0d, want 40/41", lane(0), lane(1));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_overflow();
        do_reset();
`ifdef RCU_FREELIST_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: err=%b, want 0", err);
        end
`endif
        free_en   = 2'b01;
        free_preg = {6'd0, 6'd5};
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (int'(free_cnt) !== 32 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_count: cnt=%0d full=%b, want 32/1", free_cnt, full);
        end
        alloc_req = 2'b01;
        #1;
        checks++;
        if (lane(0) !== 32) begin
            errors++;
            $display("FAIL overflow_discard: l0=%0d, want 32", lane(0));
        end
        alloc_req = 2'b00;
`ifdef RCU_FREELIST_ERR_EN
        repeat (3) cycle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, want 0", err);
        end
`endif
    endtask

    task automatic test_random();
        int n, c, spec, room, bad, exp_l;
        bit fire;
        do_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
        inflight = 0;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            alloc_req = 2'($urandom_range(0, 3));
            commit    = 2'($urandom_range(0, 3));
            if ($countones(commit) > inflight) commit = 2'b00;
            free_en   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            free_preg = 12'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            n    = $countones(alloc_req);
            spec = q.size() - inflight;
            checks++;
            if (alloc_ready !== (spec >= n) || int'(free_cnt) !== spec ||
                empty !== (spec == 0) || full !== (spec == DEPTH)) begin
                errors++;
                $display("FAIL rand_status[%0d]: rdy=%b cnt=%0d empty=%b full=%b, want cnt=%0d n=%0d",
                         cyc, alloc_ready, free_cnt, empty, full, spec, n);
            end
            if (spec >= n) begin
                checks++;
                bad = 0;
                c   = 0;
                for (int k = 0; k < 2; k++) begin
                    exp_l = alloc_req[k] ? q[inflight + c] : 0;
                    if (alloc_req[k]) c++;
                    if (lane(k) !== exp_l) bad++;
                end
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand_grant[%0d]: req=%b l0=%0d l1=%0d, %0d lanes off",
                             cyc, alloc_req, lane(0), lane(1), bad);
                end
            end
            fire = (n != 0) && (spec >= n) && !flush;
            c = $countones(commit);
            for (int i = 0; i < c; i++) void'(q.pop_front());
            inflight -= c;
            for (int j = 0; j < 2; j++) begin
                room = DEPTH - q.size();
                if (free_en[j] && room > 0) q.push_back(int'(free_preg[j*PW +: PW]));
            end
            if (fire) inflight += n;
            if (flush) inflight = 0;
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        test_reset();
        test_drain();
        test_compact();
        test_blocked();
        test_flush();
        test_wrap();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rcu_nw_freelist.md
# rcu_nw_freelist

Parametrised N-allocate / M-free physical-register freelist for the rename/commit unit (RCU). Issues up to ALLOC_PORTS free physical register tags per cycle to rename, accepts up to FREE_PORTS released tags per cycle from commit, and keeps a committed read pointer so an exception flush restores the speculative state in one cycle. It is the next-generation replacement for the fixed two-port freelist, with:
- arbitrary port counts;
- non-power-of-two depth;
- all-or-nothing allocation handshake;
- count-based occupancy.

## Interface
- PREG_WIDTH, 6: physical register tag width.
- NUM_PREGS, 64: total physical registers.
- NUM_ARCH, 32: architectural registers; DEPTH = NUM_PREGS - NUM_ARCH entries.
- ALLOC_PORTS, 2: allocation lanes per cycle (1..4).
- FREE_PORTS, 2: free lanes per cycle (1..4).
- CNT_WIDTH, $clog2(DEPTH+1): occupancy counter width.

Ports (clock and reset first):
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  exception recovery; restore speculative read state to committed state.
- alloc_req_i  in  ALLOC_PORTS  per-lane allocation request.
- alloc_ready_o  out  1  enough free entries for every requested lane.
- alloc_preg_o  out  ALLOC_PORTS*PREG_WIDTH  per-lane granted tag; lane k at bits [k*PREG_WIDTH +: PREG_WIDTH].
- commit_i  in  ALLOC_PORTS  per-lane retire of an allocating instruction; advances the committed pointer.
- free_en_i  in  FREE_PORTS  per-lane free valid.
- free_preg_i  in  FREE_PORTS*PREG_WIDTH  tags returned to the list.
- free_cnt_o  out  CNT_WIDTH  speculative free-entry count.
- empty_o  out  1  free_cnt_o == 0.
- full_o  out  1  free_cnt_o == DEPTH.
- err_o  out  1  sticky error; present only with RCU_FREELIST_ERR_EN.

## Operation
- Storage: DEPTH x PREG_WIDTH circular array.
- Pointers: wr_ptr, spec_rd_ptr, cmt_rd_ptr, all wrapping DEPTH-1 -> 0 (modulo DEPTH, not 2^n).
- Counters: spec_cnt and cmt_cnt, each = entries between its read pointer and wr_ptr.
- Reset: entry i = NUM_ARCH + i; all pointers 0; spec_cnt = cmt_cnt = DEPTH; err_o = 0.
- Allocation:
  - n = popcount(alloc_req_i); alloc_ready_o = (spec_cnt >= n).
  - Lanes are compacted: requested lane k reads entry spec_rd_ptr + (number of requested lanes below k), mod DEPTH.
  - Unrequested lanes output 0.
  - An allocation fires when n != 0, alloc_ready_o = 1 and flush_i = 0. It is all-or-nothing: no partial grant.
  - On fire, spec_rd_ptr += n and spec_cnt -= n.
- Commit: c = popcount(commit_i); cmt_rd_ptr += c; cmt_cnt -= c.
- Free:
  - f = popcount(free_en_i).
  - Valid lanes are compacted and written at wr_ptr + offset; wr_ptr += f.
  - Both counters += f.
- Overflow: if cmt_cnt + f - c > DEPTH, the excess frees (highest lanes) are discarded and not counted.
- Flush:
  - spec_rd_ptr <= cmt_rd_ptr after this cycle's commit.
  - spec_cnt <= cmt_cnt after this cycle's commit and free.
  - Allocation is suppressed in the flush cycle.
- Simultaneous free + alloc: both apply. Frees are not visible to allocation in the same cycle (no bypass).

## Timing
- alloc_ready_o and alloc_preg_o are combinational from alloc_req_i and registered state, valid in the request cycle. Rename samples them in the same cycle.
- All pointer, counter and array updates occur at the next posedge. A freed tag is allocatable from cycle +1.
- Flush takes effect at the posedge of the flush_i cycle. First post-flush allocation is in cycle +1 and returns the oldest uncommitted tag.
- Asserting rst mid-operation immediately restores the reset image and counts, regardless of the clock.
- free_cnt_o, empty_o and full_o are derived from registered spec_cnt; they are glitch-free relative to inputs.

## Configuration
- RCU_FREELIST_ERR_EN defined:
  - err_o is a sticky flag, set on any of: a commit with c > cmt_cnt; a free overflow discard; an allocation request while spec_cnt < n.
  - Cleared only by rst.
- Undefined: no err_o port. Illegal commits saturate cmt_cnt at 0; overflow frees are discarded silently.

## Test plan
- Reset, ALLOC_PORTS=2, alloc_req_i=2'b11 for 16 cycles:
  - grants 32,33 … 62,63;
  - then alloc_ready_o=0, empty_o=1, free_cnt_o=0.
- alloc_req_i=2'b10 after reset -> lane 1 = 32, lane 0 = 0; next cycle 2'b11 -> 33,34.
- Drain to 1 free entry, request 2'b11 -> alloc_ready_o=0, no pointer movement, free_cnt_o stays 1.
- Allocate 6, commit 2, flush -> free_cnt_o = 30; next allocation returns 34 (oldest uncommitted).
- With the list empty and wr_ptr at 31, free 2'b11 tags 40,41 -> written to entries 31 and 0; free_cnt_o=2; next allocation returns 40,41.
- With RCU_FREELIST_ERR_EN, list full, free 1 tag -> tag discarded, err_o=1 and held until rst.
